// File: rtl/en_demux_seq_pkg.sv
// Shared definitions for the enable demultiplexer: mode encodings and FSM state type.
package en_demux_seq_pkg;

   localparam logic [1:0] MODE_DIRECT = 2'b00;
   localparam logic [1:0] MODE_AUTO   = 2'b01;
   localparam logic [1:0] MODE_BURST  = 2'b10;
   localparam logic [1:0] MODE_BCAST  = 2'b11;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_BURST = 1'b1;

endpackage

// File: rtl/en_demux_seq_if.sv
// Control/status bundle between the controller (master) and the enable demultiplexer (slave).
interface en_demux_seq_if #(
   parameter int N_OUT = 16
) ();
   localparam int SEL_W = $clog2(N_OUT);

   logic             en_in;
   logic [1:0]       mode;
   logic [SEL_W-1:0] select;
   logic             clr;
   logic [N_OUT-1:0] en_out;
   logic [SEL_W-1:0] ptr;
   logic             last;
   logic             busy;
   logic             sel_err;

   modport master (
      output en_in, mode, select, clr,
      input  en_out, ptr, last, busy, sel_err
   );

   modport slave (
      input  en_in, mode, select, clr,
      output en_out, ptr, last, busy, sel_err
   );

endinterface

// File: rtl/en_demux_seq_onehot_dec.sv
// Combinational index-to-one-hot decoder; index k lights bit N_OUT-1-k (index 0 is the MSB).
module onehot_dec #(
   parameter int N_OUT = 16,
   parameter int SEL_W = $clog2(N_OUT)
) (
   input  logic [SEL_W-1:0] idx_i,
   output logic [N_OUT-1:0] onehot_o,
   output logic             valid_o
);

   // decode with range check; out-of-range indices yield all zeros
   always_comb begin
      valid_o  = (32'(idx_i) < N_OUT);
      onehot_o = '0;
      for (int k = 0; k < N_OUT; k++) begin
         onehot_o[N_OUT-1-k] = (32'(idx_i) == k);
      end
   end

endmodule

// File: rtl/en_demux_seq.sv
// Registered enable demultiplexer: direct, auto-step, self-timed burst sweep and broadcast modes.
module en_demux_seq
   import en_demux_seq_pkg::*;
#(
   parameter int N_OUT = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   en_demux_seq_if.slave  bus
);

   localparam int               SEL_W    = $clog2(N_OUT);
   localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N_OUT - 1);
   localparam logic [N_OUT-1:0] CH0_MASK = {1'b1, {(N_OUT-1){1'b0}}};

   state_t           state_q, state_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [N_OUT-1:0] en_out_q, en_out_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
   logic             sel_err_q, sel_err_d;

   logic [SEL_W-1:0] ptr_base_s;
   logic [SEL_W-1:0] dec_idx_s;
   logic [SEL_W-1:0] ptr_inc_s;
   logic [N_OUT-1:0] dec_onehot_s;
   logic             dec_valid_s;

   // clr in IDLE takes effect before the strobe; decoder index comes from select only in direct mode
   always_comb begin
      if (state_q == ST_BURST) begin
         ptr_base_s = ptr_q;
      end else if (bus.clr) begin
         ptr_base_s = '0;
      end else begin
         ptr_base_s = ptr_q;
      end
      if ((state_q == ST_IDLE) && (bus.mode == MODE_DIRECT)) begin
         dec_idx_s = bus.select;
      end else begin
         dec_idx_s = ptr_base_s;
      end
      if (ptr_base_s == PTR_LAST) begin
         ptr_inc_s = '0;
      end else begin
         ptr_inc_s = ptr_base_s + SEL_W'(1);
      end
   end

   onehot_dec #(
      .N_OUT (N_OUT),
      .SEL_W (SEL_W)
   ) u_dec (
      .idx_i    (dec_idx_s),
      .onehot_o (dec_onehot_s),
      .valid_o  (dec_valid_s)
   );

   // next-state logic; every output defaults to a zero pulse
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      en_out_d  = '0;
      last_d    = 1'b0;
      busy_d    = 1'b0;
      sel_err_d = 1'b0;
      case (state_q)
         ST_BURST: begin
            if (bus.clr) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               en_out_d = dec_onehot_s;
               busy_d   = 1'b1;
               ptr_d    = ptr_inc_s;
               if (ptr_q == PTR_LAST) begin
                  last_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_BURST;
               end
            end
         end
         ST_IDLE: begin
            ptr_d = ptr_base_s;
            if (bus.en_in) begin
               case (bus.mode)
                  MODE_DIRECT: begin
                     if (dec_valid_s) begin
                        en_out_d = dec_onehot_s;
                     end else begin
                        sel_err_d = 1'b1;
                     end
                  end
                  MODE_AUTO: begin
                     en_out_d = dec_onehot_s;
                     ptr_d    = ptr_inc_s;
                     last_d   = (ptr_base_s == PTR_LAST);
                  end
                  MODE_BURST: begin
                     // the sweep always begins at channel 0, whatever ptr holds
                     en_out_d = CH0_MASK;
                     ptr_d    = SEL_W'(1);
                     busy_d   = 1'b1;
                     state_d  = ST_BURST;
                  end
                  MODE_BCAST: begin
                     en_out_d = '1;
                  end
                  default: begin
                     en_out_d = '0;
                  end
               endcase
            end else begin
               en_out_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         en_out_q  <= '0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         en_out_q  <= en_out_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign bus.en_out  = en_out_q;
   assign bus.ptr     = ptr_q;
   assign bus.last    = last_q;
   assign bus.busy    = busy_q;
   assign bus.sel_err = sel_err_q;

endmodule
